// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: sequencer state encoding and default sizing shared by the PLL bring-up logic.
package pll_seq_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_LOCK, SETTLE, RELEASE, RUN, FAULT} pll_seq_state_t;
  localparam int DEF_N_PLL       = 4;
  localparam int DEF_SETTLE_CYC  = 1024;
  localparam int DEF_STAGGER_CYC = 16;
  localparam int DEF_TIMEOUT_CYC = 65536;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer bringing asynchronous level signals into the clk_1 domain.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk_1,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge clk_1) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end
  assign q = sync_q;
endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: brings up the PLL clock tree, waits for steady lock, then staggers
// per-domain reset releases; re-sequences on loss of lock and parks in FAULT on lock timeout.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int N_PLL       = DEF_N_PLL,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int STAGGER_CYC = DEF_STAGGER_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                     clk_1,
  input  logic                     rst,
  input  logic [N_PLL-1:0]         pll_locked,
  input  logic [N_PLL-1:0]         pll_en,
  input  logic                     retry,
  output logic [N_PLL-1:0]         lock_rst,
  output logic [N_PLL-1:0]         dom_rst_n,
  output logic                     all_ready,
  output logic                     fault,
  output logic [$clog2(N_PLL)-1:0] fault_idx
);
  localparam int IW = $clog2(N_PLL);
  localparam int TW = $clog2(max3(TIMEOUT_CYC, SETTLE_CYC, STAGGER_CYC));
  pll_seq_state_t state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [IW-1:0]    idx_q, idx_d, fault_idx_q, fault_idx_d, miss_idx, nxt_idx;
  logic [N_PLL-1:0] lock_rst_q, lock_rst_d, dom_rst_n_q, dom_rst_n_d;
  logic [N_PLL-1:0] lk_sync, miss, rel_mask;
  logic             all_ready_q, all_ready_d, fault_q, fault_d;
  logic             ok, nxt_ok, en_i, rel, adv, quiet;
  sync_2ff #(.W(N_PLL)) u_sync (
    .clk_1 (clk_1),
    .rst   (rst),
    .d     (pll_locked),
    .q     (lk_sync)
  );
  assign miss = pll_en & ~lk_sync;
  assign ok   = (miss == '0);
  // Lowest missing lock for fault reporting, and next enabled domain above idx for releases.
  always_comb begin
    miss_idx = '0;
    nxt_idx  = idx_q;
    nxt_ok   = 1'b0;
    for (int i = N_PLL - 1; i >= 0; i--) begin
      if (miss[i]) miss_idx = IW'(i);
      if (pll_en[i] && i > int'(idx_q)) begin
        nxt_ok  = 1'b1;
        nxt_idx = IW'(i);
      end
    end
  end
  assign en_i     = pll_en[idx_q];
  assign rel      = (state_q == RELEASE) && en_i && (timer_q == '0);
  assign rel_mask = rel ? (N_PLL'(1) << idx_q) : '0;
  // The last enabled domain waits one extra cycle so all_ready trails its release.
  assign adv      = !en_i || (nxt_ok ? (timer_q == TW'(STAGGER_CYC - 1)) : (timer_q != '0));
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    fault_idx_d = fault_idx_q;
    case (state_q)
      IDLE: begin
        state_d = WAIT_LOCK;
        timer_d = '0;
      end
      WAIT_LOCK: begin
        if (ok) begin
          state_d = SETTLE;
          timer_d = '0;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d     = FAULT;
          fault_idx_d = miss_idx;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      SETTLE: begin
        if (!ok) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == TW'(SETTLE_CYC - 1)) begin
          state_d = RELEASE;
          idx_d   = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RELEASE: begin
        if (!ok) begin
          state_d = IDLE;
        end else if (adv) begin
          timer_d = '0;
          idx_d   = nxt_ok ? nxt_idx : idx_q;
          state_d = nxt_ok ? RELEASE : RUN;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RUN:     state_d = ok ? RUN : IDLE;
      FAULT:   state_d = retry ? IDLE : FAULT;
      default: state_d = IDLE;
    endcase
  end
  assign quiet       = (state_d == IDLE) || (state_d == FAULT);
  assign lock_rst_d  = quiet ? pll_en : '0;
  assign dom_rst_n_d = quiet ? '0 : (dom_rst_n_q | rel_mask);
  assign all_ready_d = (state_d == RUN);
  assign fault_d     = (state_d == FAULT);
  always_ff @(posedge clk_1) begin
    if (!rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      fault_idx_q <= '0;
      lock_rst_q  <= '1;
      dom_rst_n_q <= '0;
      all_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      fault_idx_q <= fault_idx_d;
      lock_rst_q  <= lock_rst_d;
      dom_rst_n_q <= dom_rst_n_d;
      all_ready_q <= all_ready_d;
      fault_q     <= fault_d;
    end
  end
  assign lock_rst  = lock_rst_q;
  assign dom_rst_n = dom_rst_n_q;
  assign all_ready = all_ready_q;
  assign fault     = fault_q;
  assign fault_idx = fault_idx_q;
endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Sequences bring-up of the board's multi-PLL clock tree from the `clk_1` domain. It holds each PLL's lock detector in reset, waits for every enabled PLL to report steady lock, and lets lock settle. It then releases per-domain reset requests one domain at a time, in index order. It also detects loss of lock and timeouts, re-sequences on loss of lock, and parks in a fault state on timeout.

## Interface
- `N_PLL`, 4: number of PLLs/clock domains managed.
- `SETTLE_CYC`, 1024: `clk_1` cycles for which all enabled locks must stay high before any release.
- `STAGGER_CYC`, 16: `clk_1` cycles between consecutive domain releases.
- `TIMEOUT_CYC`, 65536: maximum `clk_1` cycles in WAIT_LOCK before FAULT.

- `clk_1`  in  1  sequencer clock.
- `rst`  in  1  reset, synchronous, active-low.
- `pll_locked`  in  `N_PLL`  `USR_PLL_LOCKED_STDY` from each PLL; asynchronous, synchronized internally.
- `pll_en`  in  `N_PLL`  mask of PLLs in use; static while `rst` is high.
- `retry`  in  1  single-cycle pulse; leaves FAULT.
- `lock_rst`  out  `N_PLL`  drives `USR_LOCKED_STDY_RST`; active-high.
- `dom_rst_n`  out  `N_PLL`  per-domain reset request, active-low; the receiving domain resynchronizes it.
- `all_ready`  out  1  high only in RUN.
- `fault`  out  1  high only in FAULT.
- `fault_idx`  out  `$clog2(N_PLL)`  index of the PLL that caused the fault.

## Operation
- **Reset values** (when `rst`=0 at a clock edge): `lock_rst`=all ones, `dom_rst_n`=0, `all_ready`=0, `fault`=0, `fault_idx`=0, state IDLE, timer=0, synchronizers cleared.
- **Lock synchronization:** `lk = sync(pll_locked) & pll_en`. `ok` is true when `lk == pll_en`; this is vacuously true when `pll_en`=0.
- **IDLE:** `lock_rst`=`pll_en`. Lasts exactly 1 cycle, then goes to WAIT_LOCK with timer=0.
- **WAIT_LOCK:** `lock_rst`=0.
  - If `ok`: go to SETTLE with timer=0.
  - Else if timer==`TIMEOUT_CYC`-1: go to FAULT, with `fault_idx` = lowest enabled index whose `lk` is 0.
  - Otherwise: increment timer.
- **SETTLE:**
  - If `!ok`: go to WAIT_LOCK with timer=0; the timeout budget restarts.
  - Else if timer==`SETTLE_CYC`-1: go to RELEASE with idx=0 and timer=0.
  - Otherwise: increment timer.
- **RELEASE:**
  - A domain is released when idx points at it, it is enabled, and timer==0: its `dom_rst_n` goes to 1 and stays 1.
  - After a release, the timer counts to `STAGGER_CYC`-1, then idx advances.
  - Disabled indices are skipped in 1 cycle, with no stagger wait.
  - After idx `N_PLL`-1 is handled, go to RUN. Disabled domains keep `dom_rst_n`=0 permanently.
- **RUN:** `all_ready`=1. On `!ok`, go to IDLE, with `dom_rst_n` all 0 and `all_ready`=0 on the same edge.
- **Loss of lock** in RELEASE also goes to IDLE and clears all `dom_rst_n`.
- **FAULT:** `lock_rst`=`pll_en`, `dom_rst_n`=0, `fault`=1. On `retry`=1, go to IDLE and clear `fault`. `fault_idx` holds its value until the next fault or reset.
- **Timer:** a single shared counter of width `$clog2(max(TIMEOUT_CYC, SETTLE_CYC, STAGGER_CYC))`. It never wraps; every compare is an equality against the parameter minus 1.
- **Simultaneous events:** `rst` overrides everything. `retry` outside FAULT is ignored.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Synchronizer latency is 2 cycles. An edge on `pll_locked` at edge t becomes visible in `lk` after edge t+2, and state/outputs react at edge t+3.
- Minimum bring-up with all PLLs enabled, counted from the first cycle with `rst`=1:
  - 1 cycle IDLE.
  - WAIT_LOCK for at least 1 cycle.
  - `SETTLE_CYC` cycles in SETTLE.
  - Domain 0 released on the first RELEASE edge.
  - Domain k released k·`STAGGER_CYC` cycles after domain 0.
  - `all_ready` 1 cycle after the last release.
- `lock_rst` pulse width on re-sequence is exactly 1 cycle.

## Structure
- Shared package `pll_seq_pkg` holds:
  - the state enum `pll_seq_state_t` (IDLE, WAIT_LOCK, SETTLE, RELEASE, RUN, FAULT);
  - default parameter constants.
- Sub-module `sync_2ff`: parameterized-width two-flop synchronizer, instantiated once with width `N_PLL`.
- The FSM, timer and idx logic all live in `pll_lock_sequencer`.

## Test plan
All scenarios use `N_PLL`=4, `SETTLE_CYC`=8, `STAGGER_CYC`=4, `TIMEOUT_CYC`=64.
1. `pll_en`=4'hF, all locks rise 5 cycles after `rst` goes high → `dom_rst_n` steps 0001, 0011, 0111, 1111 at 4-cycle spacing. `all_ready`=1 one cycle after 1111.
2. `pll_en`=4'b1011, all locks high → bits 0, 1 and 3 released 4 cycles apart. Bit 2 stays 0. `all_ready`=1.
3. `pll_locked[2]` held at 0 → `fault`=1 and `fault_idx`=2 exactly 64 cycles after WAIT_LOCK entry. `dom_rst_n`=0 and `lock_rst`=4'hF. A `retry` pulse returns to IDLE with `fault`=0.
4. `pll_locked[0]` drops for 1 cycle at SETTLE cycle 5 → return to WAIT_LOCK, then a full 8-cycle SETTLE before domain 0 is released.
5. In RUN, `pll_locked[1]` falls at edge t → `dom_rst_n`=0 and `all_ready`=0 at edge t+3, `lock_rst`=4'hF for 1 cycle, and the full sequence repeats once locks return.
6. `rst`=0 while 2 domains are released → all outputs take their reset values at the next edge. Re-sequencing starts from IDLE after `rst`=1.
